link_credit_sched: RTL and testbench

//  Per-output-link scheduler that sequences the two-VC output controller. Generates the

---
 rtl/link_credit_sched.sv | 138 +++++++++++++
 tb/tb_link_credit_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/link_credit_sched.sv
// link_credit_sched: per-output-link scheduler for a two-VC output controller.
// It generates the even/odd polarity phase (0 drains VC0, 1 drains VC1) and
// gates path_rdy on downstream credit. It also tracks per-VC credits, runs the
// INIT/RUN/PAUSE/DRAIN sequencing and flags credit protocol errors.
// Optional feature macro: LINK_STATS_EN enables the credit-stall counter
// (stall_cnt). When the macro is undefined, stall_cnt is tied to zero.
module link_credit_sched #(
  parameter int CREDITS    = 4,
  parameter int CW         = 3,
  parameter int INIT_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          dout_vld,
  input  logic          credit_ret_0,
  input  logic          credit_ret_1,
  output logic          polarity,
  output logic          path_rdy,
  output logic [CW-1:0] credit_0,
  output logic [CW-1:0] credit_1,
  output logic          flush_done,
  output logic          cred_err,
  output logic [15:0]   stall_cnt
);

  localparam int IW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_PAUSE, S_DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] init_cnt;
  logic [CW-1:0] sel_credit;
  logic          consume_0, consume_1;
  logic          over_0, over_1;
  logic          all_full;

  // NOTE: path_rdy is decoded only from registered state and credits, so no
  // input ever reaches it combinationally and no loop can form with dout_vld.
  assign sel_credit = polarity ? credit_1 : credit_0;
  assign path_rdy   = (state == S_RUN) && (sel_credit != '0);

  assign consume_0 = dout_vld && path_rdy && !polarity;
  assign consume_1 = dout_vld && path_rdy &&  polarity;

  // A return on a full counter with no matching consume is an overflow.
  assign over_0   = credit_ret_0 && !consume_0 && (credit_0 == FULL);
  assign over_1   = credit_ret_1 && !consume_1 && (credit_1 == FULL);
  assign all_full = (credit_0 == FULL) && (credit_1 == FULL);

  // Net credit change for one VC: consume and return in the same cycle cancel,
  // and an overflowing return leaves the count saturated at CREDITS.
  function automatic logic [CW-1:0] next_credit(input logic [CW-1:0] cur,
                                                 input logic consume,
                                                 input logic ret);
    logic [CW-1:0] res;
    res = cur;
    if (consume && !ret)                     res = cur - CW'(1);
    else if (ret && !consume && cur != FULL) res = cur + CW'(1);
    return res;
  endfunction

  // Sequencing FSM: state, init timer, polarity phase and flush_done pulse.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      polarity   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        S_INIT: begin
          if (init_cnt == IW'(INIT_DELAY - 1)) begin
            state <= en ? S_RUN : S_PAUSE;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
        S_RUN: begin
          polarity <= ~polarity;
          if (flush)   state <= S_DRAIN;
          else if (!en) state <= S_PAUSE;
        end
        S_PAUSE: begin
          if (flush)   state <= S_DRAIN;
          else if (en) state <= S_RUN;
        end
        S_DRAIN: begin
          polarity <= ~polarity;
          if (all_full) begin
            flush_done <= 1'b1;
            state      <= en ? S_RUN : S_PAUSE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Per-VC credit counters; returns are accepted in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_0 <= FULL;
      credit_1 <= FULL;
    end else begin
      credit_0 <= next_credit(credit_0, consume_0, credit_ret_0);
      credit_1 <= next_credit(credit_1, consume_1, credit_ret_1);
    end
  end

  // Sticky protocol error: credit overflow or a send while not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cred_err <= 1'b0;
    end else if (over_0 || over_1 || (dout_vld && !path_rdy)) begin
      cred_err <= 1'b1;
    end
  end

`ifdef LINK_STATS_EN
  // Stall statistics: count RUN cycles starved of credit, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == S_RUN && sel_credit == '0 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_link_credit_sched.sv
// Testbench for link_credit_sched. Directed sequences plus randomized traffic
// are scored against a behavioural model of the credit and phase rules.
// Expected outputs are queued per cycle; a monitor pops them and compares.
module tb_link_credit_sched;

  localparam int CREDITS    = 4;
  localparam int CW         = 3;
  localparam int INIT_DELAY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          dout_vld = 1'b0;
  logic          credit_ret_0 = 1'b0;
  logic          credit_ret_1 = 1'b0;
  logic          polarity;
  logic          path_rdy;
  logic [CW-1:0] credit_0;
  logic [CW-1:0] credit_1;
  logic          flush_done;
  logic          cred_err;
  logic [15:0]   stall_cnt;

  link_credit_sched #(.CREDITS(CREDITS), .CW(CW), .INIT_DELAY(INIT_DELAY)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .dout_vld(dout_vld),
    .credit_ret_0(credit_ret_0), .credit_ret_1(credit_ret_1),
    .polarity(polarity), .path_rdy(path_rdy), .credit_0(credit_0),
    .credit_1(credit_1), .flush_done(flush_done), .cred_err(cred_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pol; int rdy; int c0; int c1; int fd; int err; int stall;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Behavioural model: mode name, remaining init cycles, phase, credit pool.
  string m_mode = "INIT";
  int    m_init_left = INIT_DELAY;
  int    m_pol = 0;
  int    m_cred[2] = '{CREDITS, CREDITS};
  int    m_fd = 0;
  int    m_err = 0;
  int    m_stall = 0;
  bit    m_valid = 1'b0;
  int    m_flushes_done = 0;

  function automatic bit m_rdy();
    return (m_mode == "RUN") && (m_cred[m_pol] > 0);
  endfunction

  function automatic void model_step(bit r, bit e, bit f, bit dv, bit r0, bit r1);
    bit rdy;
    int nxt[2];
    bit rets[2];
    if (r) begin
      m_mode = "INIT"; m_init_left = INIT_DELAY; m_pol = 0;
      m_cred = '{CREDITS, CREDITS}; m_fd = 0; m_err = 0; m_stall = 0;
      m_valid = 1'b1;
      return;
    end
    rdy = m_rdy();
    rets[0] = r0;
    rets[1] = r1;
    if (dv && !rdy) m_err = 1;
    for (int v = 0; v < 2; v++) begin
      nxt[v] = m_cred[v] - ((dv && rdy && m_pol == v) ? 1 : 0) + (rets[v] ? 1 : 0);
      if (nxt[v] > CREDITS) begin
        nxt[v] = CREDITS;
        m_err = 1;
      end
    end
`ifdef LINK_STATS_EN
    if (m_mode == "RUN" && m_cred[m_pol] == 0 && m_stall < 65535) m_stall++;
`endif
    m_fd = 0;
    if (m_mode == "INIT") begin
      m_init_left--;
      if (m_init_left == 0) m_mode = e ? "RUN" : "PAUSE";
    end else if (m_mode == "RUN") begin
      m_pol = 1 - m_pol;
      if (f) m_mode = "DRAIN";
      else if (!e) m_mode = "PAUSE";
    end else if (m_mode == "PAUSE") begin
      if (f) m_mode = "DRAIN";
      else if (e) m_mode = "RUN";
    end else begin
      m_pol = 1 - m_pol;
      if (m_cred[0] == CREDITS && m_cred[1] == CREDITS) begin
        m_fd = 1;
        m_flushes_done++;
        m_mode = e ? "RUN" : "PAUSE";
      end
    end
    m_cred = nxt;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus: queue the expected outputs for this cycle,
  // apply the inputs, then advance the model across the coming edge.
  task automatic cycle(input bit r, input bit e, input bit f, input bit dv,
                       input bit r0, input bit r1);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; flush = f; dout_vld = dv;
    credit_ret_0 = r0; credit_ret_1 = r1;
    if (m_valid) begin
      x.pol = m_pol; x.rdy = int'(m_rdy()); x.c0 = m_cred[0]; x.c1 = m_cred[1];
      x.fd = m_fd; x.err = m_err; x.stall = m_stall;
      sb.push_back(x);
    end
    model_step(r, e, f, dv, r0, r1);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("polarity",   int'(polarity),   x.pol);
        check("path_rdy",   int'(path_rdy),   x.rdy);
        check("credit_0",   int'(credit_0),   x.c0);
        check("credit_1",   int'(credit_1),   x.c1);
        check("flush_done", int'(flush_done), x.fd);
        check("cred_err",   int'(cred_err),   x.err);
        check("stall_cnt",  int'(stall_cnt),  x.stall);
      end
    end
  end

  initial begin
    int wait_cycles;
    bit dv, r0, r1;
    // Reset, then the INIT hold and polarity toggling.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 0, 0, 0);
    // Send whenever ready with no returns: drains to 0/0, then starves.
    repeat (14) cycle(0, 1, 0, m_rdy(), 0, 0);
    // Return two VC0 credits, then consume and return VC0 together.
    cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      dv = m_rdy() && (m_pol == 0);
      cycle(0, 1, 0, dv, dv, 0);
    end
    // Pause: polarity frozen while returns still land.
    repeat (3) cycle(0, 0, 0, 0, 1, 0);
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    // Overflow on VC1 raises a sticky error.
    cycle(1, 1, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    repeat (4) cycle(0, 1, 0, 0, 0, 0);
    // Credits 1/2, flush, returns trickle back, flush_done then RUN.
    cycle(1, 1, 0, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    repeat (5) cycle(0, 1, 0, m_rdy(), 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 1, 1);
    cycle(0, 1, 0, 0, 1, 1);
    cycle(0, 1, 0, 0, 1, 0);
    repeat (4) cycle(0, 1, 0, 0, 0, 0);
    // Flush entered already full, with en low: exits to PAUSE.
    cycle(0, 0, 1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0);
    // Randomized protocol-legal traffic with occasional flush/pause/reset.
    for (int i = 0; i < 1500; i++) begin
      dv = m_rdy() && ($urandom_range(0, 2) != 0);
      r0 = (m_cred[0] < CREDITS) && ($urandom_range(0, 2) == 0);
      r1 = (m_cred[1] < CREDITS) && ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 39) == 0, dv, r0, r1);
    end
    // Unconstrained traffic, including overflows and sends while not ready.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #2;
    check("scoreboard_drained", sb.size(), 0);
    check("flush_completions_seen", int'(m_flushes_done > 1), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
